booth_seq_mult: RTL and testbench

- Sequential radix-2 Booth signed multiplier; the initiator side of the 2-bit ALU op protocol (01 = add, 10 = subtract).
- Per iteration it decides the add/subtract step, performs it on an internal W+1-bit accumulator, then arithmetic-shifts.
- Exposes each issued step on step_op so benches and the integrating datapath can trace it.
- Sits beside the ALU in the booth-multiplier datapath; the start/busy/done handshake is used by upstream control.

---
 rtl/booth_seq_mult.sv | 106 ++++++++++
 tb/tb_booth_seq_mult.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier: one ADD cycle and one SHIFT cycle per multiplier bit.
// Issues ALU-style step codes (01 add, 10 sub) on step_op_o for tracing by the datapath.
module booth_seq_mult #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   multiplicand_i,
  input  logic [W-1:0]   multiplier_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] product_o,
  output logic [1:0]     step_op_o
);

  localparam int unsigned CntW = $clog2(W) + 1;

  typedef enum logic [1:0] {StIdle, StAdd, StShift} state_e;

  state_e            state_q;
  logic [W:0]        m_q, a_q, a_d;
  logic [W-1:0]      q_q;
  logic              q1_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q;
  logic [2*W-1:0]    product_q;
  logic [1:0]        step_op;

  // Step decode is only meaningful in ADD; every other state reports no step.
  always_comb begin
    step_op = 2'b00;
    a_d     = a_q;
    if (state_q == StAdd) begin
      unique case ({q_q[0], q1_q})
        2'b01: begin
          step_op = 2'b01;
          a_d     = a_q + m_q;
        end
        2'b10: begin
          step_op = 2'b10;
          a_d     = a_q - m_q;
        end
        default: begin
          step_op = 2'b00;
          a_d     = a_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            m_q     <= {multiplicand_i[W-1], multiplicand_i};
            a_q     <= '0;
            q_q     <= multiplier_i;
            q1_q    <= 1'b0;
            cnt_q   <= CntW'(W);
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          a_q     <= a_d;
          state_q <= StShift;
        end
        StShift: begin
          // Arithmetic right shift of {A,Q,q_1}; the low W bits of A plus Q form the product.
          a_q   <= {a_q[W], a_q[W:1]};
          q_q   <= {a_q[0], q_q[W-1:1]};
          q1_q  <= q_q[0];
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            product_q <= {a_q, q_q[W-1:1]};
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            state_q <= StAdd;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;
  assign step_op_o = step_op;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed-vector bench for booth_seq_mult (W=4): products, step traces, handshake and reset.
module tb_booth_seq_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] mc, mr;
  logic       busy, done;
  logic [7:0] product;
  logic [1:0] step_op;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  last_prod = 8'h00;

  booth_seq_mult #(.W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .multiplicand_i(mc),
    .multiplier_i  (mr),
    .busy_o        (busy),
    .done_o        (done),
    .product_o     (product),
    .step_op_o     (step_op)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered #1 after an edge with the DUT idle (or on its done cycle). exp_ops packs the four
  // ADD-cycle step codes, first step in the top bits.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp_p,
                        input logic [7:0] exp_ops, input bit poke, input bit chain);
    int unsigned busy_n = 0;
    bit          early_done = 1'b0;
    bit          held = 1'b1;
    logic [7:0]  ops = 8'h00;
    logic [1:0]  shift_ops = 2'b00;
    start = 1'b1;
    mc    = m;
    mr    = q;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (busy) busy_n++;
      if (done) early_done = 1'b1;
      if (product !== last_prod) held = 1'b0;
      if (k % 2 == 1) ops = {ops[5:0], step_op};
      else shift_ops = shift_ops | step_op;
      if (poke && k == 3) begin
        start = 1'b1;
        mc    = 4'h2;
        mr    = 4'h2;
      end
      if (poke && k == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("busy_cycles", busy_n, 8);
    check_eq("no_early_done", early_done, 0);
    check_eq("product_held", held, 1);
    check_eq("step_ops", ops, exp_ops);
    check_eq("shift_step_none", shift_ops, 0);
    check_eq("done_pulse", done, 1);
    check_eq("busy_low_at_done", busy, 0);
    check_eq("product", product, exp_p);
    last_prod = exp_p;
    if (!chain) begin
      @(posedge clk); #1;
      check_eq("done_one_cycle", done, 0);
      check_eq("product_hold_after", product, exp_p);
    end
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    mc    = 4'h0;
    mr    = 4'h0;
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_product", product, 0);
    check_eq("rst_step_op", step_op, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'h3, 4'h5, 8'h0F, 8'h99, 1'b0, 1'b0);   //  3 *  5 = 15
    run_op(4'h8, 4'h8, 8'h40, 8'h02, 1'b0, 1'b0);   // -8 * -8 = 64
    run_op(4'h8, 4'h7, 8'hC8, 8'h81, 1'b0, 1'b0);   // -8 *  7 = -56
    run_op(4'h7, 4'hF, 8'hF9, 8'h80, 1'b0, 1'b0);   //  7 * -1 = -7
    run_op(4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op(4'h5, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0);
    // Start during busy is ignored; start on the done cycle launches the next op.
    run_op(4'h3, 4'h5, 8'h0F, 8'h99, 1'b1, 1'b1);
    run_op(4'h2, 4'h2, 8'h04, 8'h24, 1'b0, 1'b0);

    // Reset in the middle of 6*6.
    start = 1'b1;
    mc    = 4'h6;
    mr    = 4'h6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("pre_rst_step_op", step_op, 2'b10);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_product", product, 0);
    check_eq("mid_rst_step_op", step_op, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check_eq("rst_no_done", saw_done, 0);
    last_prod = 8'h00;
    run_op(4'hD, 4'h4, 8'hF4, 8'h09, 1'b0, 1'b0);   // -3 * 4 = -12

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1);
  end

endmodule
